// File: rtl/capture_sequencer_pkg.sv
// Shared types and defaults for the capture-and-replay sequencer.
package capture_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    CAPTURE     = 3'd1,
    FETCH       = 3'd2,
    LATCH       = 3'd3,
    SEND        = 3'd4,
    WAIT_FILTER = 3'd5
  } capture_state_t;

  localparam int SAMPLE_DATA_WIDTH_DEFAULT = 8;
  localparam int CAPTURE_LENGTH_DEFAULT    = 1000;
  localparam int SAMPLE_TIMEOUT_DEFAULT    = 100_000;

endpackage

// File: rtl/capture_sequencer_if.sv
// Playback stream towards the filter: valid/ready with a last-sample marker.
interface capture_sequencer_if #(
  parameter int DW = 8
) ();
  logic          axiov;
  logic [DW-1:0] axiod;
  logic          axiol;
  logic          axior;

  modport master (output axiov, output axiod, output axiol, input axior);
  modport slave  (input axiov, input axiod, input axiol, output axior);
endinterface

// File: rtl/capture_sequencer.sv
// Captures CAPTURE_LENGTH samples into an external buffer on trigger, then
// replays them to the filter and waits for its completion pulse.
module capture_sequencer
  import capture_pkg::*;
#(
  parameter int SAMPLE_DATA_WIDTH = SAMPLE_DATA_WIDTH_DEFAULT,
  parameter int CAPTURE_LENGTH    = CAPTURE_LENGTH_DEFAULT,
  parameter int ADDR_WIDTH        = $clog2(CAPTURE_LENGTH),
  parameter int SAMPLE_TIMEOUT    = SAMPLE_TIMEOUT_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         trigger,
  input  logic                         axiiv,
  input  logic [SAMPLE_DATA_WIDTH-1:0] axiid,
  output logic                         buf_we,
  output logic [ADDR_WIDTH-1:0]        buf_waddr,
  output logic [SAMPLE_DATA_WIDTH-1:0] buf_wdata,
  output logic [ADDR_WIDTH-1:0]        buf_raddr,
  input  logic [SAMPLE_DATA_WIDTH-1:0] buf_rdata,
  capture_sequencer_if.master          play,
  input  logic                         filter_done,
  output logic                         busy,
  output logic                         done,
  output logic                         error
);

  localparam int                    TMO_WIDTH = $clog2(SAMPLE_TIMEOUT + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(CAPTURE_LENGTH - 1);
  localparam logic [TMO_WIDTH-1:0]  TMO_LIMIT = TMO_WIDTH'(SAMPLE_TIMEOUT);

  capture_state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0]         wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0]         rd_ptr_q, rd_ptr_d;
  logic [TMO_WIDTH-1:0]          tmo_q, tmo_d;
  logic                          error_q, error_d;
  logic                          done_q, done_d;
  logic                          busy_q, busy_d;
  logic                          axiov_q, axiov_d;
  logic [SAMPLE_DATA_WIDTH-1:0]  axiod_q, axiod_d;
  logic                          axiol_q, axiol_d;

  logic                          sample_s;
  logic                          last_wr_s;
  logic                          timeout_s;
  logic                          hs_s;
  logic [TMO_WIDTH-1:0]          tmo_inc_s;

  assign sample_s  = (state_q == CAPTURE) && axiiv;
  assign last_wr_s = sample_s && (wr_ptr_q == LAST_ADDR);
  assign tmo_inc_s = (tmo_q == TMO_LIMIT) ? tmo_q : tmo_q + TMO_WIDTH'(1);
  assign timeout_s = (state_q == CAPTURE) && !axiiv && (tmo_inc_s >= TMO_LIMIT);
  assign hs_s      = (state_q == SEND) && axiov_q && play.axior;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (trigger) state_d = CAPTURE;
        else         state_d = IDLE;
      end
      CAPTURE: begin
        if (last_wr_s)      state_d = FETCH;
        else if (timeout_s) state_d = IDLE;
        else                state_d = CAPTURE;
      end
      FETCH: state_d = LATCH;
      LATCH: state_d = SEND;
      SEND: begin
        if (hs_s) state_d = axiol_q ? WAIT_FILTER : FETCH;
        else      state_d = SEND;
      end
      WAIT_FILTER: begin
        if (filter_done) state_d = IDLE;
        else             state_d = WAIT_FILTER;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pointer, timeout and output-register next values
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    tmo_d    = tmo_q;
    error_d  = error_q;
    axiod_d  = axiod_q;
    axiol_d  = axiol_q;
    case (state_q)
      IDLE: begin
        if (trigger) begin
          wr_ptr_d = '0;
          tmo_d    = '0;
          error_d  = 1'b0;
        end else begin
          wr_ptr_d = wr_ptr_q;
        end
      end
      CAPTURE: begin
        if (sample_s) begin
          wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
          tmo_d    = '0;
          if (last_wr_s) rd_ptr_d = '0;
          else           rd_ptr_d = rd_ptr_q;
        end else begin
          tmo_d = tmo_inc_s;
          if (timeout_s) error_d = 1'b1;
          else           error_d = error_q;
        end
      end
      LATCH: begin
        axiod_d = buf_rdata;
        axiol_d = (rd_ptr_q == LAST_ADDR);
      end
      SEND: begin
        // The last sample leaves rd_ptr untouched; it is reloaded on the next full capture.
        if (hs_s && !axiol_q) rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
        else                  rd_ptr_d = rd_ptr_q;
      end
      default: begin
        wr_ptr_d = wr_ptr_q;
      end
    endcase
    axiov_d = (state_d == SEND);
    busy_d  = (state_d != IDLE);
    done_d  = (state_q == WAIT_FILTER) && filter_done;
  end

  // Datapath and registered-output storage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      tmo_q    <= '0;
      error_q  <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      axiov_q  <= 1'b0;
      axiod_q  <= '0;
      axiol_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      tmo_q    <= tmo_d;
      error_q  <= error_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      axiov_q  <= axiov_d;
      axiod_q  <= axiod_d;
      axiol_q  <= axiol_d;
    end
  end

  // Buffer writes are zero-latency; address/data are forced to zero when idle.
  assign buf_we    = sample_s;
  assign buf_waddr = sample_s ? wr_ptr_q : '0;
  assign buf_wdata = sample_s ? axiid : '0;
  assign buf_raddr = (state_q == FETCH) ? rd_ptr_q : '0;

  assign play.axiov = axiov_q;
  assign play.axiod = axiod_q;
  assign play.axiol = axiol_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// Table-driven scoreboard bench for capture_sequencer (CAPTURE_LENGTH=4, SAMPLE_TIMEOUT=50).
module tb_capture_sequencer;

  localparam int DW  = 8;
  localparam int LEN = 4;
  localparam int TMO = 50;
  localparam int AW  = 2;

  logic          clk;
  logic          rst_n;
  logic          trigger;
  logic          axiiv;
  logic [DW-1:0] axiid;
  logic          buf_we;
  logic [AW-1:0] buf_waddr;
  logic [DW-1:0] buf_wdata;
  logic [AW-1:0] buf_raddr;
  logic [DW-1:0] buf_rdata;
  logic          filter_done;
  logic          busy;
  logic          done;
  logic          error;

  capture_sequencer_if #(.DW(DW)) pv ();

  capture_sequencer #(
    .SAMPLE_DATA_WIDTH(DW),
    .CAPTURE_LENGTH   (LEN),
    .ADDR_WIDTH       (AW),
    .SAMPLE_TIMEOUT   (TMO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .trigger    (trigger),
    .axiiv      (axiiv),
    .axiid      (axiid),
    .buf_we     (buf_we),
    .buf_waddr  (buf_waddr),
    .buf_wdata  (buf_wdata),
    .buf_raddr  (buf_raddr),
    .buf_rdata  (buf_rdata),
    .play       (pv),
    .filter_done(filter_done),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural buffer with one-cycle read latency.
  logic [DW-1:0] mem [0:LEN-1];
  always @(posedge clk) begin
    if (buf_we) mem[buf_waddr] <= buf_wdata;
    buf_rdata <= mem[buf_raddr];
  end

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } pl_t;

  typedef struct {
    logic [3:0][DW-1:0] smp;
    logic [3:0][DW-1:0] exp;
    int                 gap;
    int                 stall;
    bit                 ign_first;
    bit                 trig_send;
    bit                 trig_fdone;
    int                 fdelay;
  } vec_t;

  wr_t  wr_q [$];
  pl_t  pl_q [$];
  wr_t  w_exp;
  pl_t  p_exp;
  int   vectors    = 0;
  int   miscompares = 0;
  int   hs_cnt     = 0;
  int   done_cnt   = 0;
  vec_t tbl [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Write-port and playback scoreboards, sampled mid-cycle.
  always @(negedge clk) begin
    if (buf_we) begin
      if (wr_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h", buf_waddr, buf_wdata);
      end else begin
        w_exp = wr_q.pop_front();
        chk("wr_addr", 32'(buf_waddr), 32'(w_exp.addr));
        chk("wr_data", 32'(buf_wdata), 32'(w_exp.data));
      end
    end
    if (pv.axiov && pv.axior) begin
      hs_cnt++;
      if (pl_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_playback: data 0x%0h last %0b", pv.axiod, pv.axiol);
      end else begin
        p_exp = pl_q.pop_front();
        chk("play_data", 32'(pv.axiod), 32'(p_exp.data));
        chk("play_last", 32'(pv.axiol), 32'(p_exp.last));
      end
    end
    if (done) done_cnt++;
  end

  function automatic vec_t mk(input logic [DW-1:0] s0, s1, s2, s3,
                              input logic [DW-1:0] e0, e1, e2, e3,
                              input int gap, stall, input bit ign, tsend, tfd,
                              input int fdelay);
    vec_t v;
    v.smp = {s3, s2, s1, s0};
    v.exp = {e3, e2, e1, e0};
    v.gap = gap;
    v.stall = stall;
    v.ign_first = ign;
    v.trig_send = tsend;
    v.trig_fdone = tfd;
    v.fdelay = fdelay;
    return v;
  endfunction

  task automatic check_all_zero();
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_axiov", 32'(pv.axiov), 32'd0);
    chk("rst_axiod", 32'(pv.axiod), 32'd0);
    chk("rst_axiol", 32'(pv.axiol), 32'd0);
    chk("rst_buf_we", 32'(buf_we), 32'd0);
    chk("rst_buf_waddr", 32'(buf_waddr), 32'd0);
    chk("rst_buf_wdata", 32'(buf_wdata), 32'd0);
    chk("rst_buf_raddr", 32'(buf_raddr), 32'd0);
  endtask

  task automatic run_pass(input vec_t v);
    int n;
    hs_cnt  = 0;
    trigger = 1'b1;
    if (v.ign_first) begin
      axiiv = 1'b1;
      axiid = 8'hEE;
    end
    step();
    trigger = 1'b0;
    for (int i = 0; i < LEN; i++) begin
      axiiv = 1'b0;
      repeat (v.gap) step();
      axiiv = 1'b1;
      axiid = v.smp[i];
      wr_q.push_back('{addr: AW'(i), data: v.smp[i]});
      pl_q.push_back('{data: v.exp[i], last: (i == LEN - 1)});
      if (i == 0) begin
        @(negedge clk);
        chk("busy_in_capture", 32'(busy), 32'd1);
        chk("error_cleared", 32'(error), 32'd0);
      end
      step();
    end
    axiiv = 1'b0;
    if (v.stall > 0) begin
      n = 0;
      while (hs_cnt < 1 && n < 100) begin step(); n++; end
      pv.axior = 1'b0;
      n = 0;
      while (!pv.axiov && n < 100) begin step(); n++; end
      repeat (v.stall) begin
        @(negedge clk);
        chk("stall_valid", 32'(pv.axiov), 32'd1);
        chk("stall_data", 32'(pv.axiod), 32'(v.exp[1]));
        chk("stall_last", 32'(pv.axiol), 32'd0);
        step();
      end
      pv.axior = 1'b1;
    end
    if (v.trig_send) begin
      n = 0;
      while (!pv.axiov && n < 100) begin step(); n++; end
      trigger = 1'b1;
      step();
      trigger = 1'b0;
    end
    n = 0;
    while (hs_cnt < LEN && n < 300) begin step(); n++; end
    chk("handshake_count", 32'(hs_cnt), 32'(LEN));
    repeat (v.fdelay) step();
    @(negedge clk);
    chk("wait_done_low", 32'(done), 32'd0);
    chk("wait_busy", 32'(busy), 32'd1);
    chk("wait_valid_low", 32'(pv.axiov), 32'd0);
    step();
    filter_done = 1'b1;
    if (v.trig_fdone) trigger = 1'b1;
    @(negedge clk);
    chk("done_not_early", 32'(done), 32'd0);
    step();
    filter_done = 1'b0;
    trigger     = 1'b0;
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_after_done", 32'(busy), 32'd0);
    step();
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("idle_after_pass", 32'(busy), 32'd0);
    chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
    chk("pl_q_drained", 32'(pl_q.size()), 32'd0);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int dc;
    tbl[0] = mk(8'h11, 8'h22, 8'h33, 8'h44, 8'h11, 8'h22, 8'h33, 8'h44, 20, 0, 1'b0, 1'b0, 1'b0, 10);
    tbl[1] = mk(8'h11, 8'h22, 8'h33, 8'h44, 8'h11, 8'h22, 8'h33, 8'h44,  2, 7, 1'b0, 1'b0, 1'b0, 3);
    tbl[2] = mk(8'hC3, 8'h5E, 8'h00, 8'hFF, 8'hC3, 8'h5E, 8'h00, 8'hFF,  1, 0, 1'b1, 1'b1, 1'b1, 0);
    tbl[3] = mk(8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0, 8'hA1, 8'hA2, 8'hA3,  0, 0, 1'b0, 1'b0, 1'b0, 5);

    rst_n = 1'b0; trigger = 1'b0; axiiv = 1'b0; axiid = '0;
    filter_done = 1'b0; pv.axior = 1'b1;
    repeat (3) step();
    @(negedge clk);
    check_all_zero();
    step();
    rst_n = 1'b1;
    step();

    // filter_done while idle must not produce done
    filter_done = 1'b1;
    step();
    filter_done = 1'b0;
    @(negedge clk);
    chk("idle_fdone_done", 32'(done), 32'd0);
    chk("idle_fdone_busy", 32'(busy), 32'd0);
    step();

    for (int i = 0; i < 4; i++) run_pass(tbl[i]);

    // Timeout: two samples then silence
    step();
    dc = done_cnt;
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    axiiv = 1'b1; axiid = 8'h5A;
    wr_q.push_back('{addr: 2'd0, data: 8'h5A});
    step();
    axiiv = 1'b0;
    repeat (3) step();
    axiiv = 1'b1; axiid = 8'hA5;
    wr_q.push_back('{addr: 2'd1, data: 8'hA5});
    step();
    axiiv = 1'b0;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (error) break;
      step();
      n++;
    end
    chk("timeout_latency", 32'(n), 32'(TMO));
    chk("timeout_busy", 32'(busy), 32'd0);
    chk("timeout_no_play", 32'(pv.axiov), 32'd0);
    chk("timeout_no_done", 32'(done_cnt - dc), 32'd0);
    chk("timeout_wr_q", 32'(wr_q.size()), 32'd0);
    step();
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    @(negedge clk);
    chk("retrigger_clears_error", 32'(error), 32'd0);
    chk("retrigger_busy", 32'(busy), 32'd1);
    step();

    // Reset in the middle of this capture
    axiiv = 1'b1; axiid = 8'h01;
    wr_q.push_back('{addr: 2'd0, data: 8'h01});
    step();
    axiiv = 1'b1; axiid = 8'h02;
    wr_q.push_back('{addr: 2'd1, data: 8'h02});
    step();
    axiiv = 1'b0;
    rst_n = 1'b0;
    step();
    axiiv = 1'b1; axiid = 8'h77;
    @(negedge clk);
    check_all_zero();
    step();
    axiiv = 1'b0;
    rst_n = 1'b1;
    step();
    run_pass(tbl[3]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
